keypad_scan_decoder: RTL

- Parametrised successor to the team's 4x4 combinational keypad decoder.
- Drives the keypad rows itself and samples the columns through a synchroniser.
- Debounces on whole scan frames, rejects multi-key presses and emits a key code with press/release strobes.
- Sits between the keypad pins and the display/accumulator logic; replaces the external row synchroniser plus decoder pair.

---
 rtl/keypad_scan_decoder.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/keypad_scan_decoder.sv
// keypad_scan_decoder: drives a ROWS x COLS matrix keypad one row at a time.
// Each column sample passes through a 2-flop synchroniser. Samples are
// gathered into whole-frame results: NONE, SINGLE(idx) or MULTI. A result is
// accepted once it has been identical for DEBOUNCE_FRAMES consecutive frames.
// Accepted results drive a small press/release FSM with registered outputs.
// Optional macro KEYPAD_HEX_MAP_EN: on a 4x4 keypad, key codes follow the
// telephone hex layout instead of the raw row*COLS+col index.
module keypad_scan_decoder #(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int SCAN_DIV        = 4,
  parameter int DEBOUNCE_FRAMES = 3,
  parameter int KEY_W           = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [COLS-1:0]  cols,
  output logic [ROWS-1:0]  row_drive,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  output logic             key_release,
  output logic             key_held,
  output logic             multi_err
);

  localparam int RW = $clog2(ROWS);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int SW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic [RW-1:0] LAST_ROW   = RW'(ROWS - 1);
  localparam logic [DW-1:0] LAST_DIV   = DW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_FRAMES);
  localparam logic [SW-1:0] STABLE_PRE = SW'(DEBOUNCE_FRAMES - 1);

  // Key-count encoding shared by row, frame and previous-frame results.
  localparam logic [1:0] CNT_NONE   = 2'd0;
  localparam logic [1:0] CNT_SINGLE = 2'd1;
  localparam logic [1:0] CNT_MULTI  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESSED,
    S_MULTI
  } state_t;

  // Adds two key counts, saturating at "two or more".
  function automatic logic [1:0] sat_cnt(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 3'd2) ? CNT_MULTI : s[1:0];
  endfunction

  // Maps a raw key index to the reported key code.
  function automatic logic [KEY_W-1:0] key_map(input logic [KEY_W-1:0] idx);
`ifdef KEYPAD_HEX_MAP_EN
    logic [3:0] hex;
    if (ROWS == 4 && COLS == 4) begin
      case (int'(idx))
        0:       hex = 4'h1;
        1:       hex = 4'h2;
        2:       hex = 4'h3;
        3:       hex = 4'hA;
        4:       hex = 4'h4;
        5:       hex = 4'h5;
        6:       hex = 4'h6;
        7:       hex = 4'hB;
        8:       hex = 4'h7;
        9:       hex = 4'h8;
        10:      hex = 4'h9;
        11:      hex = 4'hC;
        12:      hex = 4'hF;
        13:      hex = 4'h0;
        14:      hex = 4'hE;
        default: hex = 4'hD;
      endcase
      return KEY_W'(hex);
    end
    return idx;
`else
    return idx;
`endif
  endfunction

  logic [COLS-1:0]  cols_p0;
  logic [COLS-1:0]  cols_p1;
  logic [RW-1:0]    row_idx;
  logic [RW-1:0]    row_next;
  logic [DW-1:0]    div_cnt;
  logic             sample;
  logic             frame_end;
  logic [1:0]       row_cnt;
  logic [CW-1:0]    row_col;
  logic [KEY_W-1:0] row_key;
  logic [1:0]       acc_cnt;
  logic [KEY_W-1:0] acc_idx;
  logic [1:0]       mrg_cnt;
  logic [KEY_W-1:0] mrg_idx;
  logic [1:0]       prev_cnt;
  logic [KEY_W-1:0] prev_idx;
  logic [SW-1:0]    stable_cnt;
  logic             same;
  logic             accept;
  state_t           state;

  // Stage p0/p1: two-flop synchroniser for the asynchronous column inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cols_p0 <= '0;
      cols_p1 <= '0;
    end else begin
      cols_p0 <= cols;
      cols_p1 <= cols_p0;
    end
  end

  // Row dwell counter and registered one-hot row strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt   <= '0;
      row_idx   <= '0;
      row_drive <= ROWS'(1);
    end else if (div_cnt == LAST_DIV) begin
      div_cnt   <= '0;
      row_idx   <= row_next;
      row_drive <= ROWS'(1) << row_next;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Column scan of the current row merged into the running frame result.
  always_comb begin
    row_next  = (row_idx == LAST_ROW) ? '0 : row_idx + 1'b1;
    sample    = (div_cnt == LAST_DIV);
    frame_end = sample && (row_idx == LAST_ROW);
    row_cnt   = CNT_NONE;
    row_col   = '0;
    for (int c = 0; c < COLS; c++) begin
      if (cols_p1[c]) begin
        if (row_cnt == CNT_NONE) row_col = CW'(c);
        row_cnt = sat_cnt(row_cnt, CNT_SINGLE);
      end
    end
    row_key = KEY_W'(row_idx) * KEY_W'(COLS) + KEY_W'(row_col);
    mrg_cnt = sat_cnt(acc_cnt, row_cnt);
    if (acc_cnt != CNT_NONE)      mrg_idx = acc_idx;
    else if (row_cnt != CNT_NONE) mrg_idx = row_key;
    else                          mrg_idx = '0;
    same   = (mrg_cnt == prev_cnt) && ((mrg_cnt != CNT_SINGLE) || (mrg_idx == prev_idx));
    accept = frame_end && (same ? (stable_cnt == STABLE_PRE) : (DEBOUNCE_FRAMES == 1));
  end

  // Stage p2: frame accumulator and frame-level debounce history.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_cnt    <= CNT_NONE;
      acc_idx    <= '0;
      prev_cnt   <= CNT_NONE;
      prev_idx   <= '0;
      stable_cnt <= '0;
    end else if (sample) begin
      if (frame_end) begin
        acc_cnt  <= CNT_NONE;
        acc_idx  <= '0;
        prev_cnt <= mrg_cnt;
        prev_idx <= mrg_idx;
        if (!same)                         stable_cnt <= SW'(1);
        else if (stable_cnt != STABLE_MAX) stable_cnt <= stable_cnt + 1'b1;
      end else begin
        acc_cnt <= mrg_cnt;
        acc_idx <= mrg_idx;
      end
    end
  end

  // Press/release FSM advanced only by accepted frame results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      key_code    <= '0;
      key_valid   <= 1'b0;
      key_release <= 1'b0;
      key_held    <= 1'b0;
      multi_err   <= 1'b0;
    end else begin
      key_valid   <= 1'b0;
      key_release <= 1'b0;
      if (accept) begin
        case (state)
          S_IDLE: begin
            if (mrg_cnt == CNT_SINGLE) begin
              state     <= S_PRESSED;
              key_code  <= key_map(mrg_idx);
              key_valid <= 1'b1;
              key_held  <= 1'b1;
            end else if (mrg_cnt == CNT_MULTI) begin
              state     <= S_MULTI;
              multi_err <= 1'b1;
            end
          end
          S_PRESSED: begin
            if (mrg_cnt == CNT_NONE) begin
              state       <= S_IDLE;
              key_release <= 1'b1;
              key_held    <= 1'b0;
            end else if (mrg_cnt == CNT_MULTI) begin
              state     <= S_MULTI;
              key_held  <= 1'b0;
              multi_err <= 1'b1;
            end
          end
          S_MULTI: begin
            if (mrg_cnt == CNT_NONE) begin
              state     <= S_IDLE;
              multi_err <= 1'b0;
            end
          end
          default: begin
            state     <= S_IDLE;
            key_held  <= 1'b0;
            multi_err <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
